// File: rtl/mult_pkg.sv
// Shared types and defaults for the multiplier / accumulator datapath.
// Product width default, operand width and the accumulator state type.
package mult_pkg;

  localparam int DEF_PROD_W = 8;
  localparam int OP_W       = 4;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

endpackage

// File: rtl/acc_add.sv
// Accumulator adder: ACC_W-bit acc plus PROD_W-bit product with carry-out.
// MULT_ACC_SAT_EN clamps the sum to all-ones on carry instead of wrapping.
module acc_add #(
  parameter int ACC_W  = 10,
  parameter int PROD_W = 8
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);

  logic [ACC_W:0] raw;

  assign raw   = {1'b0, acc} + (ACC_W+1)'(prod);
  assign carry = raw[ACC_W];

`ifdef MULT_ACC_SAT_EN
  assign sum = carry ? '1 : raw[ACC_W-1:0];
`else
  assign sum = raw[ACC_W-1:0];
`endif

endmodule

// File: rtl/mult_accumulator.sv
// Sums LEN products per result behind valid/ready handshakes.
// Define MULT_ACC_SAT_EN for a saturating accumulator (default wraps).
module mult_accumulator
  import mult_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int LEN    = 4,
  parameter int ACC_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);

  localparam int CNT_W = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic [ACC_W-1:0] sum;
  logic             carry;

  acc_add #(
    .ACC_W  (ACC_W),
    .PROD_W (PROD_W)
  ) u_add (
    .acc   (acc),
    .prod  (in_product),
    .sum   (sum),
    .carry (carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
      cnt   <= '0;
      acc   <= '0;
      ovf   <= 1'b0;
    end else if (clear) begin
      state <= ACCUM;
      cnt   <= '0;
      acc   <= '0;
      ovf   <= 1'b0;
    end else begin
      unique case (state)
        ACCUM: begin
          if (in_valid) begin
            // first term restarts the sum and the sticky flag
            if (cnt == '0) begin
              acc <= ACC_W'(in_product);
              ovf <= 1'b0;
            end else begin
              acc <= sum;
              ovf <= ovf | carry;
            end
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= DONE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        DONE: begin
          if (out_ready) state <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign out_sum   = acc;
  assign out_ovf   = ovf;

endmodule

// File: tb/tb_mult_accumulator.sv
// Self-checking bench: LEN=4 and LEN=8 instances against a sum model.
// Honours MULT_ACC_SAT_EN for the expected overflow behaviour.
module tb_mult_accumulator;

  typedef int iq_t[$];

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic [7:0] in_product;
  logic       out_ready;

  logic       r4, v4, o4;
  logic [9:0] s4;
  logic       r8, v8, o8;
  logic [9:0] s8;

  int tests = 0;
  int fails = 0;

  mult_accumulator #(.PROD_W(8), .LEN(4), .ACC_W(10)) u4 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(r4), .in_product(in_product),
    .out_valid(v4), .out_ready(out_ready),
    .out_sum(s4), .out_ovf(o4)
  );

  mult_accumulator #(.PROD_W(8), .LEN(8), .ACC_W(10)) u8 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(r8), .in_product(in_product),
    .out_valid(v8), .out_ready(out_ready),
    .out_sum(s8), .out_ovf(o8)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic obs_rdy(bit big);
    return big ? r8 : r4;
  endfunction
  function automatic logic obs_vld(bit big);
    return big ? v8 : v4;
  endfunction
  function automatic logic [9:0] obs_sum(bit big);
    return big ? s8 : s4;
  endfunction
  function automatic logic obs_ovf(bit big);
    return big ? o8 : o4;
  endfunction

  function automatic iq_t rep(int v, int n);
    iq_t q;
    for (int i = 0; i < n; i++) q.push_back(v);
    return q;
  endfunction

  // Result = plain integer total; overflow iff total exceeds 10 bits.
  function automatic void model(input iq_t pv, output int s, output bit o);
    int tot = 0;
    foreach (pv[i]) tot += pv[i];
    o = (tot > 1023);
`ifdef MULT_ACC_SAT_EN
    s = o ? 1023 : tot;
`else
    s = tot % 1024;
`endif
  endfunction

  task automatic run(input bit big, input iq_t pv, input int gaps,
                     input int hold, input string nm);
    int n = pv.size();
    int k = 0;
    int cyc = 0;
    int es;
    bit eo;
    model(pv, es, eo);
    clear = 1'b1;
    in_valid = 1'b1;
    in_product = 8'($urandom);
    out_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    tests++;
    if (obs_rdy(big) !== 1'b1 || obs_vld(big) !== 1'b0) begin
      fails++;
      $display("FAIL %s clear rdy=%b vld=%b want 1 0",
               nm, obs_rdy(big), obs_vld(big));
    end
    while (k < n && cyc < 500) begin
      case (gaps)
        1: in_valid = ((cyc % 2) == 0);
        2: in_valid = 1'($urandom_range(0, 1));
        default: in_valid = 1'b1;
      endcase
      in_product = in_valid ? pv[k][7:0] : 8'($urandom);
      @(posedge clk);
      if (in_valid) k++;
      @(negedge clk);
      cyc++;
      if (k < n) begin
        tests++;
        if (obs_rdy(big) !== 1'b1 || obs_vld(big) !== 1'b0) begin
          fails++;
          $display("FAIL %s early rdy=%b vld=%b want 1 0 k=%0d",
                   nm, obs_rdy(big), obs_vld(big), k);
        end
      end
    end
    in_valid = 1'b0;
    tests++;
    if (k < n) begin
      fails++;
      $display("FAIL %s timeout k=%0d want %0d", nm, k, n);
    end
    tests++;
    if (obs_vld(big) !== 1'b1 || obs_rdy(big) !== 1'b0 ||
        obs_sum(big) !== 10'(es) || obs_ovf(big) !== eo) begin
      fails++;
      $display("FAIL %s result vld=%b rdy=%b sum=%0d ovf=%b want 1 0 %0d %b",
               nm, obs_vld(big), obs_rdy(big), obs_sum(big),
               obs_ovf(big), es, eo);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      tests++;
      if (obs_vld(big) !== 1'b1 || obs_rdy(big) !== 1'b0 ||
          obs_sum(big) !== 10'(es)) begin
        fails++;
        $display("FAIL %s hold%0d vld=%b rdy=%b sum=%0d want 1 0 %0d",
                 nm, h, obs_vld(big), obs_rdy(big), obs_sum(big), es);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (obs_vld(big) !== 1'b0 || obs_rdy(big) !== 1'b1) begin
      fails++;
      $display("FAIL %s release vld=%b rdy=%b want 0 1",
               nm, obs_vld(big), obs_rdy(big));
    end
  endtask

  task automatic feed(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_product = 8'(p);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic sync_clear();
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear = 1'b0;
    in_valid = 1'b0;
    in_product = '0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (r4 !== 1'b1 || v4 !== 1'b0 || s4 !== 10'd0 || o4 !== 1'b0) begin
      fails++;
      $display("FAIL reset rdy=%b vld=%b sum=%0d ovf=%b want 1 0 0 0",
               r4, v4, s4, o4);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (r8 !== 1'b1 || v8 !== 1'b0 || s8 !== 10'd0 || o8 !== 1'b0) begin
      fails++;
      $display("FAIL reset8 rdy=%b vld=%b sum=%0d ovf=%b want 1 0 0 0",
               r8, v8, s8, o8);
    end
  endtask

  task automatic test_basic();
    iq_t q;
    q = {10, 20, 30, 40};
    run(1'b0, q, 0, 0, "basic");
  endtask

  task automatic test_back_pressure();
    iq_t q;
    q = {10, 20, 30, 40};
    run(1'b0, q, 0, 5, "bp");
    run(1'b0, rep(1, 4), 0, 0, "bp_next");
  endtask

  task automatic test_gaps();
    run(1'b0, rep(225, 4), 1, 0, "gaps");
  endtask

  task automatic test_overflow();
    run(1'b1, rep(225, 8), 0, 0, "ovf");
    run(1'b1, rep(1, 8), 0, 0, "ovf_next");
  endtask

  task automatic test_clear();
    sync_clear();
    feed(int'($urandom_range(1, 255)), 2);
    run(1'b0, rep(5, 4), 0, 0, "clear");
    sync_clear();
    out_ready = 1'b0;
    feed(5, 4);
    tests++;
    if (v4 !== 1'b1 || s4 !== 10'd20) begin
      fails++;
      $display("FAIL clear_done vld=%b sum=%0d want 1 20", v4, s4);
    end
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    tests++;
    if (v4 !== 1'b0 || r4 !== 1'b1 || s4 !== 10'd0) begin
      fails++;
      $display("FAIL clear_drop vld=%b rdy=%b sum=%0d want 0 1 0",
               v4, r4, s4);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_async_reset();
    sync_clear();
    in_valid = 1'b1;
    in_product = 8'd100;
    @(posedge clk);
    @(negedge clk);
    in_product = 8'd50;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    tests++;
    if (s4 !== 10'd150) begin
      fails++;
      $display("FAIL areset_pre sum=%0d want 150", s4);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (r4 !== 1'b1 || v4 !== 1'b0 || s4 !== 10'd0 || o4 !== 1'b0) begin
      fails++;
      $display("FAIL areset rdy=%b vld=%b sum=%0d ovf=%b want 1 0 0 0",
               r4, v4, s4, o4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run(1'b0, rep(3, 4), 0, 0, "areset_after");
  endtask

  task automatic test_random();
    for (int t = 0; t < 16; t++) begin
      bit big = 1'($urandom_range(0, 1));
      int n = big ? 8 : 4;
      iq_t q;
      for (int i = 0; i < n; i++)
        q.push_back(($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255)));
      run(big, q, 2, int'($urandom_range(0, 3)), "rand");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_pressure();
    test_gaps();
    test_overflow();
    test_clear();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mult_accumulator.md
# mult_accumulator

Sequential accumulation stage directly downstream of the 4x4 combinational multiplier. It consumes the multiplier's 8-bit product stream through a valid/ready handshake and sums a fixed number of products, LEN. It then presents the sum as one result through a second valid/ready handshake. Together with the multiplier it forms a dot-product datapath for small vector operands.

## Interface
- PROD_W, 8: product width; matches the multiplier output.
- LEN, 4: number of products summed per result; must be ≥ 1.
- ACC_W, 10: accumulator and result width.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low.
- clear  input  1  synchronous abort; discards partial sum and returns to ACCUM.
- in_valid  input  1  product on in_product is valid.
- in_ready  output  1  block accepts a product this cycle.
- in_product  input  PROD_W  unsigned product from the multiplier.
- out_valid  output  1  result is valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  ACC_W  accumulated result.
- out_ovf  output  1  a carry out of ACC_W occurred during this result.

## Operation
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Input accept: in_valid && in_ready at a rising edge.
  - First term of a result (cnt==0): acc ← in_product, zero-extended. The ovf flag is cleared.
  - Later terms: acc ← acc + in_product, computed ACC_W+1 bits wide. A carry-out sets the sticky ovf flag.
  - cnt increments. When cnt reaches LEN-1 on an accept, the next state is DONE and cnt returns to 0.
- In DONE: out_sum=acc and out_ovf=ovf are held stable while out_valid=1. On out_ready the next state is ACCUM.
- clear has priority over everything else: next state ACCUM, cnt←0, acc←0, ovf←0. It drops a pending result in DONE.
- in_product is ignored whenever in_valid=0 or in_ready=0.
- cnt width is $clog2(LEN+1).
- With LEN=1, every accept goes directly to DONE.

## Timing
- Reset values:
  - state=ACCUM, cnt=0, acc=0, ovf=0.
  - in_ready=1, out_valid=0, out_sum=0, out_ovf=0.
- All outputs are registered or decoded from state only. There are no combinational paths from input to output.
- Latency: if the LEN-th accept occurs at edge k, out_valid=1 after edge k.
- Throughput: at most one result per LEN+1 cycles.
  - The result handshake takes at least one cycle in DONE.
  - There is no bypass: in_ready stays 0 during the cycle in which out_ready is taken.
- Back-pressure: while out_ready=0, the block stays in DONE indefinitely and out_sum is held constant.
- Reset asserted mid-operation: all state is cleared immediately, without waiting for a clock edge.
- clear asserted together with in_valid: the product is discarded. After the edge, cnt=0.

## Configuration
- MULT_ACC_SAT_EN defined:
  - On carry-out, acc saturates to 2^ACC_W−1.
  - Later terms keep it saturated.
  - out_ovf=1.
- MULT_ACC_SAT_EN undefined:
  - acc wraps modulo 2^ACC_W.
  - out_ovf still reports that wrap occurred.

## Structure
- Shared package mult_pkg holds:
  - PROD_W default and the operand width (4).
  - The state enum type, with members ACCUM and DONE.
- One sub-module is natural: acc_add. It is an (ACC_W)-bit + (PROD_W)-bit adder producing the sum and carry-out, with the saturation option controlled by MULT_ACC_SAT_EN.
- The FSM, counter and registers live in mult_accumulator.

## Test plan
- **Basic sum.** Reset, then products 10, 20, 30, 40 on consecutive cycles with out_ready=1. Required: out_valid=1 one cycle after the 4th accept, out_sum=100, out_ovf=0; in_ready=0 for exactly one cycle.
- **Back-pressure.** As the basic-sum test, but out_ready=0 for 5 cycles. Required: out_sum stays at 100 and in_ready stays 0 throughout. When out_ready rises, the next result starts from 0; products 1, 1, 1, 1 give 4.
- **Input gaps.** in_valid toggles 1,0,1,0,… with products 225 ×4. Required: out_sum=900; only accepted beats count.
- **Overflow.** LEN=8, ACC_W=10, eight products of 225. Required:
  - MULT_ACC_SAT_EN defined: out_sum=1023, out_ovf=1.
  - Macro undefined: out_sum=776, out_ovf=1.
  - The following result (products 1 ×8) gives out_sum=8, out_ovf=0.
- **Clear.** clear after 2 accepts, asserted together with in_valid. Then products 5 ×4. Required: out_sum=20. A second clear while in DONE drops out_valid the next cycle.
- **Async reset.** rst_n low mid-accumulation, between clock edges. Required: in_ready=1, out_valid=0, out_sum=0 immediately. After release, products 3 ×4 give 12.
